// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions for the TX serializer and RX checker:
//            FSM state encoding, parity-type and bit-order constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Serializer FSM encoding
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Parity type selector values (par_odd input)
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Bit order selector values (msb_first input)
  localparam logic LSB_FIRST = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_parity_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_parity_gen
// Purpose  : Combinational parity of a DATA_W-bit word. Result is the XOR of
//            all data bits, inverted when odd parity is selected, so the
//            word plus parity bit carries the requested number of ones.
// Ports    : data    in  DATA_W  word to protect
//            par_odd in  1       0 = even parity, 1 = odd parity
//            par_bit out 1       parity bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_parity_gen #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par_odd,
  output logic              par_bit
);

  assign par_bit = (^data) ^ par_odd;

endmodule : uart_parity_gen
`default_nettype wire

// File: rtl/uart_param_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_param_serializer
// Purpose  : Parametrised parallel-to-serial shifter for the UART TX path.
//            Captures a word on a valid/ready handshake, shifts it out one
//            bit per baud tick (LSB- or MSB-first), supports synchronous
//            abort and provides the frame parity of the captured word.
// Ports    : clk       in  1       clock
//            rst       in  1       asynchronous active-low reset
//            p_data    in  DATA_W  parallel word, sampled in the load cycle
//            p_valid   in  1       load request
//            p_ready   out 1       load can be accepted (state is IDLE)
//            msb_first in  1       bit order, sampled at load
//            par_odd   in  1       parity type, sampled at load
//            bit_tick  in  1       baud strobe, advances one bit
//            abort     in  1       synchronous cancel of the current word
//            ser_data  out 1       serial bit (registered)
//            ser_done  out 1       one-cycle pulse with the last bit
//            par_bit   out 1       parity of the captured word (registered)
// Revision : 1.0 - initial release
// ============================================================================
module uart_param_serializer
  import uart_pkg::*;
#(
  parameter int   DATA_W   = 8,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] p_data,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic              msb_first,
  input  logic              par_odd,
  input  logic              bit_tick,
  input  logic              abort,
  output logic              ser_data,
  output logic              ser_done,
  output logic              par_bit
);

  localparam int                 c_CNT_W = $clog2(DATA_W);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_W - 1);

  state_t              r_state;
  logic [DATA_W-1:0]   r_shift;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_msb_first;

  logic                w_par;
  logic                w_edge_bit;

  // Parity is taken from the live input word; it is only registered in the
  // load cycle, so later changes on p_data/par_odd cannot disturb par_bit.
  uart_parity_gen #(
    .DATA_W (DATA_W)
  ) u_parity (
    .data    (p_data),
    .par_odd (par_odd),
    .par_bit (w_par)
  );

  // The bit leaving next sits at the edge the register shifts toward.
  assign w_edge_bit = r_msb_first ? r_shift[DATA_W-1] : r_shift[0];

  assign p_ready = (r_state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_msb_first <= 1'b0;
      ser_data    <= IDLE_LVL;
      ser_done    <= 1'b0;
      par_bit     <= 1'b0;
    end else begin
      ser_done <= 1'b0;
      if (abort) begin
        // Abort wins over load and tick; par_bit keeps the last frame value.
        r_state  <= IDLE;
        r_cnt    <= '0;
        ser_data <= IDLE_LVL;
      end else begin
        case (r_state)
          IDLE: begin
            if (p_valid) begin
              // A coincident bit_tick is deliberately dropped here.
              r_shift     <= p_data;
              r_msb_first <= msb_first;
              par_bit     <= w_par;
              r_cnt       <= '0;
              r_state     <= SHIFT;
            end else if (bit_tick) begin
              // Only return to idle level on a tick so the last bit of the
              // previous word is held for a full bit period.
              ser_data <= IDLE_LVL;
            end
          end
          SHIFT: begin
            if (bit_tick) begin
              ser_data <= w_edge_bit;
              r_shift  <= r_msb_first ? (r_shift << 1) : (r_shift >> 1);
              if (r_cnt == c_LAST) begin
                ser_done <= 1'b1;
                r_cnt    <= '0;
                r_state  <= IDLE;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule : uart_param_serializer
`default_nettype wire
